// File: rtl/clk_rst_pkg.sv
// Shared types and default parameters for the clk_rst_seq reset sequencer.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_FILT   = 2'd1,
        S_PERIPH = 2'd2,
        S_RUN    = 2'd3
    } state_e;

    localparam int SYNC_STAGES_DEF   = 3;
    localparam int LOCK_FILT_CYC_DEF = 1024;
    localparam int PERIPH_DLY_DEF    = 64;
    localparam int CNT_W_DEF         = 8;

    // Counters run up to limit-1; one spare bit keeps small limits safe.
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/clk_rst_seq_if.sv
// Reset-sequencer bus: lock status in, staged resets/ready/loss count out.
interface clk_rst_seq_if #(
    parameter int CNT_W = clk_rst_pkg::CNT_W_DEF
);
    logic             locked;
    logic             rst_core_n;
    logic             rst_periph_n;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_cnt;

    modport master (
        input  locked,
        output rst_core_n,
        output rst_periph_n,
        output ready,
        output lock_loss_cnt
    );

    modport slave (
        output locked,
        input  rst_core_n,
        input  rst_periph_n,
        input  ready,
        input  lock_loss_cnt
    );
endinterface

// File: rtl/rst_sync_bit.sv
// N-stage single-bit synchroniser with asynchronous active-low clear.
module rst_sync_bit #(
    parameter int N = clk_rst_pkg::SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[N-2:0], d_i};
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/clk_rst_seq.sv
// Lock-filtered staged reset sequencer (core, then peripherals, then ready).
// Build option CLK_RST_LOSS_CNT_EN enables the saturating lock-loss counter.
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int LOCK_FILT_CYC = LOCK_FILT_CYC_DEF,
    parameter int PERIPH_DLY    = PERIPH_DLY_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_rst_seq_if.master bus
);
    localparam int FW = cnt_width(LOCK_FILT_CYC);
    localparam int DW = cnt_width(PERIPH_DLY);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT_CYC - 1);
    localparam logic [DW-1:0] DLY_LAST  = DW'(PERIPH_DLY - 1);

    logic          locked_s;
    state_e        state_q, state_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          core_n_q, periph_n_q, ready_q;

    rst_sync_bit #(.N(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.locked),
        .q_o   (locked_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HOLD;
            filt_q  <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            dly_q   <= dly_d;
        end
    end

    // A low locked_s always wins over a counter reaching its limit.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        dly_d   = dly_q;
        unique case (state_q)
            S_HOLD: begin
                dly_d = '0;
                if (locked_s) begin
                    state_d = S_FILT;
                    filt_d  = FW'(1);
                end else begin
                    filt_d  = '0;
                end
            end
            S_FILT: begin
                if (!locked_s) begin
                    state_d = S_HOLD;
                    filt_d  = '0;
                end else if (filt_q == FILT_LAST) begin
                    state_d = S_PERIPH;
                    filt_d  = '0;
                    dly_d   = '0;
                end else begin
                    filt_d  = filt_q + FW'(1);
                end
            end
            S_PERIPH: begin
                if (!locked_s) begin
                    state_d = S_HOLD;
                    dly_d   = '0;
                end else if (dly_q == DLY_LAST) begin
                    state_d = S_RUN;
                    dly_d   = '0;
                end else begin
                    dly_d   = dly_q + DW'(1);
                end
            end
            S_RUN: begin
                if (!locked_s) state_d = S_HOLD;
            end
            default: begin
                state_d = S_HOLD;
                filt_d  = '0;
                dly_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the registered state and registered once more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_n_q   <= 1'b0;
            periph_n_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            core_n_q   <= (state_q == S_PERIPH) || (state_q == S_RUN);
            periph_n_q <= (state_q == S_RUN);
            ready_q    <= periph_n_q && (state_q == S_RUN);
        end
    end

    assign bus.rst_core_n   = core_n_q;
    assign bus.rst_periph_n = periph_n_q;
    assign bus.ready        = ready_q;

`ifdef CLK_RST_LOSS_CNT_EN
    logic             loss_evt;
    logic [CNT_W-1:0] loss_cnt_q;

    // Loss only counts once the core has been released; glitches in S_FILT do not.
    assign loss_evt = ((state_q == S_PERIPH) || (state_q == S_RUN)) && !locked_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         loss_cnt_q <= '0;
        else if (loss_evt && !(&loss_cnt_q)) loss_cnt_q <= loss_cnt_q + CNT_W'(1);
    end

    assign bus.lock_loss_cnt = loss_cnt_q;
`else
    assign bus.lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq (SYNC=3, FILT=8, PERIPH_DLY=4, CNT_W=2).
module tb_clk_rst_seq;
    localparam int CW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    clk_rst_seq_if #(.CNT_W(CW)) bus ();

    clk_rst_seq #(
        .SYNC_STAGES   (3),
        .LOCK_FILT_CYC (8),
        .PERIPH_DLY    (4),
        .CNT_W         (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int losses);
`ifdef CLK_RST_LOSS_CNT_EN
        return (losses > 3) ? 32'd3 : 32'(losses);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk_out(input string tag, input logic core, input logic periph,
                           input logic rdy, input logic [31:0] cnt);
        chk({tag, "/core"},   32'(bus.rst_core_n),   32'(core));
        chk({tag, "/periph"}, 32'(bus.rst_periph_n), 32'(periph));
        chk({tag, "/ready"},  32'(bus.ready),        32'(rdy));
        chk({tag, "/cnt"},    32'(bus.lock_loss_cnt), cnt);
    endtask

    // done = edges of the sequence (edge 0 = first sampling locked=1) already past.
    task automatic seq_check(input string tag, input int done, input int losses);
        step(11 - done);
        chk({tag, "/core@10"}, 32'(bus.rst_core_n), 32'd0);
        step(1);
        chk({tag, "/core@11"}, 32'(bus.rst_core_n), 32'd1);
        chk({tag, "/periph@11"}, 32'(bus.rst_periph_n), 32'd0);
        step(3);
        chk({tag, "/periph@14"}, 32'(bus.rst_periph_n), 32'd0);
        step(1);
        chk({tag, "/periph@15"}, 32'(bus.rst_periph_n), 32'd1);
        chk({tag, "/ready@15"}, 32'(bus.ready), 32'd0);
        step(1);
        chk_out({tag, "@16"}, 1'b1, 1'b1, 1'b1, exp_cnt(losses));
    endtask

    initial begin
        bus.locked = 1'b0;
        rst_n = 1'b0;
        step(3);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        step(3);
        chk_out("hold", 1'b0, 1'b0, 1'b0, 32'd0);

        bus.locked = 1'b1;
        seq_check("t1", 0, 0);

        // Fresh start, then a short lock pulse that must not release anything.
        rst_n = 1'b0;
        bus.locked = 1'b0;
        #1;
        chk_out("rst2", 1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        step(2);
        bus.locked = 1'b1;
        step(5);
        chk("glitch/hi", 32'(bus.rst_core_n), 32'd0);
        bus.locked = 1'b0;
        step(2);
        chk("glitch/lo", 32'(bus.rst_core_n), 32'd0);
        bus.locked = 1'b1;
        seq_check("t2", 0, 0);

        for (int i = 1; i <= 4; i++) begin
            string tag;
            tag = $sformatf("loss%0d", i);
            bus.locked = 1'b0;
            step(3);
            bus.locked = 1'b1;
            step(1);
            chk({tag, "/core@3"}, 32'(bus.rst_core_n), 32'd1);
            step(1);
            chk_out({tag, "@4"}, 1'b0, 1'b0, 1'b0, exp_cnt(i));
            if (i < 4) begin
                seq_check(tag, 2, i);
            end else begin
                step(9);
                chk({tag, "/core@10"}, 32'(bus.rst_core_n), 32'd0);
                step(2);
                chk({tag, "/core@12"}, 32'(bus.rst_core_n), 32'd1);
                chk({tag, "/periph@12"}, 32'(bus.rst_periph_n), 32'd0);
                rst_n = 1'b0;
                #1;
                chk_out("async_rst", 1'b0, 1'b0, 1'b0, 32'd0);
                #1;
                rst_n = 1'b1;
                seq_check("restart", 0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
